// File: rtl/usb_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : usb_data_buffer
// Description : Shared half-duplex byte FIFO between the AHB-Lite slave and the
//               USB serial engines, with show-ahead head outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_data_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_tx_data,
    input  logic [7:0]        tx_data,
    input  logic              get_rx_data,
    output logic [7:0]        rx_data,
    input  logic              store_rx_packet_data,
    input  logic [7:0]        rx_packet_data,
    input  logic              get_tx_packet_data,
    output logic [7:0]        tx_packet_data,
    input  logic              flush,
    input  logic              clear,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              buffer_overflow,
    output logic              buffer_underflow
);

    localparam logic [ADDR_W:0]   c_full_level = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_occ_one    = (ADDR_W + 1)'(1);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_occ;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push;
    logic              w_pop;
    logic [7:0]        w_wdata;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic              w_wr_conflict;
    logic              w_empty_req;
    logic [7:0]        w_head;

    assign w_push        = store_rx_packet_data | store_tx_data;
    assign w_pop         = get_tx_packet_data | get_rx_data;
    // The receiver always wins a write collision; the host byte is lost.
    assign w_wdata       = store_rx_packet_data ? rx_packet_data : tx_data;
    assign w_wr_conflict = store_rx_packet_data & store_tx_data;
    assign w_empty_req   = flush | clear;

    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == c_full_level);
    assign w_pop_ok  = w_pop & ~w_empty;
    // A simultaneous pop frees the slot being written, so a full buffer still accepts.
    assign w_push_ok = w_push & (~w_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_occ       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_empty_req) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_occ       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_occ <= r_occ + c_occ_one;
            end else if (w_pop_ok && !w_push_ok) begin
                r_occ <= r_occ - c_occ_one;
            end
            r_overflow  <= (w_push & ~w_push_ok) | w_wr_conflict;
            r_underflow <= w_pop & ~w_pop_ok;
        end
    end

    // Storage carries no reset; stale bytes are masked by the empty check below.
    always_ff @(posedge clk) begin
        if (!rst && !w_empty_req && w_push_ok) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    assign w_head = w_empty ? 8'h00 : r_mem[r_rptr];

    assign tx_packet_data   = w_head;
    assign rx_data          = w_head;
    assign buffer_occupancy = r_occ;
    assign buffer_overflow  = r_overflow;
    assign buffer_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_usb_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_data_buffer
// Description : Directed and randomized checks of usb_data_buffer against a
//               queue-based model of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_data_buffer;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = 8'h00;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] tx_packet_data;
    logic       flush = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] buffer_occupancy;
    logic       buffer_overflow;
    logic       buffer_underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic       exp_ovf;
    logic       exp_udf;

    always #5 tb_clk = ~tb_clk;

    usb_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk                  (tb_clk),
        .rst                  (rst),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .flush                (flush),
        .clear                (clear),
        .buffer_occupancy     (buffer_occupancy),
        .buffer_overflow      (buffer_overflow),
        .buffer_underflow     (buffer_underflow)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the buffer is an ordered list of at most 64 bytes.
    task automatic model(input bit r, input bit fl, input bit cl,
                         input bit srx, input logic [7:0] drx,
                         input bit stx, input logic [7:0] dtx,
                         input bit gtx, input bit grx);
        bit popped;
        bit push;
        bit pop;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        if (r || fl || cl) begin
            q.delete();
        end else begin
            push   = srx | stx;
            pop    = gtx | grx;
            popped = 1'b0;
            if (pop) begin
                if (q.size() == 0) exp_udf = 1'b1;
                else               popped  = 1'b1;
            end
            if (popped) void'(q.pop_front());
            if (push) begin
                if (q.size() < 64) q.push_back(srx ? drx : dtx);
                else               exp_ovf = 1'b1;
            end
            if (srx && stx) exp_ovf = 1'b1;
        end
    endtask

    task automatic cycle(input string tag, input bit r, input bit fl, input bit cl,
                         input bit srx, input logic [7:0] drx,
                         input bit stx, input logic [7:0] dtx,
                         input bit gtx, input bit grx);
        logic [7:0] exp_head;
        rst = r; flush = fl; clear = cl;
        store_rx_packet_data = srx; rx_packet_data = drx;
        store_tx_data = stx; tx_data = dtx;
        get_tx_packet_data = gtx; get_rx_data = grx;
        model(r, fl, cl, srx, drx, stx, dtx, gtx, grx);
        @(posedge tb_clk);
        #1;
        exp_head = (q.size() == 0) ? 8'h00 : q[0];
        chk({tag, ".occ"},  {1'b0, buffer_occupancy}, 8'(q.size()));
        chk({tag, ".txh"},  tx_packet_data, exp_head);
        chk({tag, ".rxh"},  rx_data, exp_head);
        chk({tag, ".ovf"},  {7'd0, buffer_overflow}, {7'd0, exp_ovf});
        chk({tag, ".udf"},  {7'd0, buffer_underflow}, {7'd0, exp_udf});
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    initial begin
        // Reset
        cycle("rst0", 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        cycle("rst1", 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        chk("rst.occ_const", {1'b0, buffer_occupancy}, 8'h00);
        chk("rst.head_const", tx_packet_data, 8'h00);

        // Receiver fill and transmitter drain
        cycle("fill_a5", 0, 0, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        cycle("fill_3c", 0, 0, 0, 1, 8'h3C, 0, 8'h00, 0, 0);
        cycle("fill_ff", 0, 0, 0, 1, 8'hFF, 0, 8'h00, 0, 0);
        chk("fill.head_a5", tx_packet_data, 8'hA5);
        cycle("drain0", 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        chk("drain.head_3c", tx_packet_data, 8'h3C);
        cycle("drain1", 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        cycle("drain2", 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        chk("drain.empty_occ", {1'b0, buffer_occupancy}, 8'h00);
        cycle("pop_empty", 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1);

        // Full and wrap-around
        for (int i = 0; i < 64; i++) cycle("fill64", 0, 0, 0, 0, 8'h00, 1, 8'(i), 0, 0);
        chk("full.occ64", {1'b0, buffer_occupancy}, 8'd64);
        cycle("full_push99", 0, 0, 0, 0, 8'h00, 1, 8'h99, 0, 0);
        chk("full.head0", tx_packet_data, 8'h00);
        cycle("full_pushpop", 0, 0, 0, 0, 8'h00, 1, 8'h40, 1, 0);
        chk("full.head1", tx_packet_data, 8'h01);
        idle("idle_full");
        for (int i = 0; i < 64; i++) cycle("drain64", 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);

        // Empty boundary: push and pop together
        cycle("empty_pushpop", 0, 0, 0, 1, 8'h5A, 0, 8'h00, 1, 0);
        chk("empty.head5a", rx_data, 8'h5A);

        // Write conflict: receiver byte wins
        cycle("conflict", 0, 0, 0, 1, 8'h22, 1, 8'h11, 0, 0);
        cycle("conflict_pop", 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        chk("conflict.head22", tx_packet_data, 8'h22);

        // Flush priority over push and pop
        cycle("clear0", 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) cycle("fill5", 0, 0, 0, 1, 8'(8'hC0 + i), 0, 8'h00, 0, 0);
        cycle("flush_busy", 0, 1, 0, 1, 8'hEE, 0, 8'h00, 1, 0);
        cycle("after_flush", 0, 0, 0, 0, 8'h00, 1, 8'h77, 0, 0);
        cycle("clear_busy", 0, 0, 1, 0, 8'h00, 1, 8'h66, 0, 1);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bit r, fl, cl, srx, stx, gtx, grx;
            bias = ((i / 250) % 2 == 0) ? 75 : 25;
            r   = ($urandom_range(0, 299) == 0);
            fl  = ($urandom_range(0, 99) == 0);
            cl  = ($urandom_range(0, 99) == 0);
            srx = ($urandom_range(0, 99) < bias);
            stx = ($urandom_range(0, 99) < bias / 3);
            gtx = ($urandom_range(0, 99) < 100 - bias);
            grx = ($urandom_range(0, 99) < (100 - bias) / 3);
            cycle("rand", r, fl, cl, srx, 8'($urandom), stx, 8'($urandom), gtx, grx);
        end

        while (q.size() > 0) cycle("final_drain", 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        idle("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_data_buffer.md
# usb_data_buffer

Shared 64-byte FIFO between the AHB-Lite slave and the USB serial engines, sitting directly upstream of the USB transmitter. The host side loads outgoing payload bytes and drains received bytes; the transmitter pops bytes through `get_tx_packet_data`; the receiver pushes bytes through `store_rx_packet_data`. The buffer reports its fill level to both the transmitter and the host via `buffer_occupancy`. Traffic is half-duplex, so one FIFO serves both directions.

## Interface

Parameters:
- DEPTH, 64: byte capacity. Must be a power of two.
- ADDR_W, 6: pointer width, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- store_tx_data  in  1  host write strobe; pushes `tx_data`.
- tx_data  in  8  host byte to push.
- get_rx_data  in  1  host read strobe; pops the head.
- rx_data  out  8  head byte presented to the host.
- store_rx_packet_data  in  1  receiver write strobe; pushes `rx_packet_data`.
- rx_packet_data  in  8  receiver byte to push.
- get_tx_packet_data  in  1  transmitter read strobe; pops the head.
- tx_packet_data  out  8  head byte presented to the transmitter.
- flush  in  1  empty the buffer, from the receiver at start of packet.
- clear  in  1  empty the buffer, from a host register write.
- buffer_occupancy  out  ADDR_W+1  number of bytes held, 0..64.
- buffer_overflow  out  1  one-cycle pulse when a push is rejected.
- buffer_underflow  out  1  one-cycle pulse when a pop is rejected.

## Operation

- Storage: DEPTH×8 memory, write pointer `wptr`, read pointer `rptr` (ADDR_W bits each), and an occupancy counter (ADDR_W+1 bits).
- Pointer wrap: pointers increment modulo DEPTH; 63 wraps to 0.
- Push request: `push = store_rx_packet_data | store_tx_data`.
  - If both strobes are high, the receiver byte is written and the host byte is dropped. `buffer_overflow` pulses in that cycle.
- Pop request: `pop = get_tx_packet_data | get_rx_data`.
  - If both strobes are high, only one byte is removed.
- Show-ahead: `tx_packet_data` and `rx_data` both equal mem[rptr] combinationally when occupancy > 0, and 8'h00 when empty.
- Priority within a cycle:
  1. `rst`
  2. `flush | clear`
  3. push/pop
- `flush` or `clear` sets wptr = rptr = 0 and occupancy = 0. Any same-cycle push or pop is discarded and raises no error pulse.
- Full (occupancy = 64):
  - Push alone is rejected: memory and pointers unchanged, `buffer_overflow` pulses.
  - Push and pop together: both are performed and occupancy stays 64.
- Empty (occupancy = 0):
  - Pop alone is rejected and `buffer_underflow` pulses.
  - Push and pop together: the push is performed, the pop is rejected, `buffer_underflow` pulses, and occupancy becomes 1.
- Occupancy update per cycle: +1 on an accepted push only, −1 on an accepted pop only, unchanged when both or neither are accepted.
- Memory contents are not reset and are never observable while empty.

## Timing

- Reset values: `buffer_occupancy` = 0, `tx_packet_data` = `rx_data` = 8'h00, `buffer_overflow` = `buffer_underflow` = 0, both pointers = 0.
- Push latency: a byte pushed at edge N is on the head outputs (if the buffer was empty) and counted in `buffer_occupancy` after edge N, i.e. one cycle.
- Pop latency: a pop at edge N presents the next byte on the head outputs after edge N. A strobe held high pops once per cycle.
- Error pulses are registered, high for exactly the cycle after the offending edge.
- `rst` asserted mid-burst takes effect at the next edge. In-flight pushes and pops in that cycle are discarded.
- Consumers must sample the head before or on the edge at which they pop.

## Test plan

- Reset: hold `rst` 2 cycles with strobes idle -> occupancy 0, head 8'h00, no error pulses.
- Receiver fill and transmitter drain: push 8'hA5, 8'h3C, 8'hFF -> occupancy 3, head 8'hA5. Pop 3 times -> head sequence A5, 3C, FF, then 8'h00 with occupancy 0.
- Full and wrap-around:
  - Push 64 bytes (values 0..63) -> occupancy 64.
  - Push 8'h99 -> `buffer_overflow` pulses, occupancy 64, head 0.
  - Push 8'h40 and pop together -> occupancy 64, head 1, byte 8'h40 stored at index 0.
- Empty boundary: push and pop together on an empty buffer -> `buffer_underflow` pulses, occupancy 1, head equals the pushed byte.
- Flush priority: with occupancy 5, assert `flush` together with a push and a pop -> occupancy 0 next cycle, no error pulse; the next push lands at index 0.
- Write conflict: assert `store_tx_data` (8'h11) and `store_rx_packet_data` (8'h22) together -> 8'h22 stored, occupancy +1, `buffer_overflow` pulses.
